// File: rtl/event_sequencer.sv
// rtl/event_sequencer.sv - board-square event sequencer: announce, effect, completion tick, one-deep pending slot.
// Optional effect watchdog (timeout_flag port) is built when EVENT_TIMEOUT_EN is defined.
module event_sequencer #(
    parameter int ANNOUNCE_CYC = 50_000_000,
    parameter int TIMEOUT_CYC  = 300_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       event_req,
    input  logic [3:0] event_code,
    input  logic       req_player,
    input  logic       anim_done,
    output logic       busy,
    output logic       ui_event_valid,
    output logic [3:0] ui_event_id,
    output logic       ui_player,
    output logic       effect_start,
    output logic       event_end_tick,
    output logic       game_over,
    output logic       overflow,
    output logic       bad_code,
`ifdef EVENT_TIMEOUT_EN
    output logic       timeout_flag,
`endif
    output logic [7:0] event_count
);

    // One shared phase counter serves both the announce timer and the watchdog.
    localparam int LIMIT_MAX = (ANNOUNCE_CYC > TIMEOUT_CYC) ? ANNOUNCE_CYC : TIMEOUT_CYC;
    localparam int CNT_W     = (LIMIT_MAX > 2) ? $clog2(LIMIT_MAX) : 1;
    localparam logic [CNT_W-1:0] ANN_LAST = CNT_W'(ANNOUNCE_CYC - 1);
`ifdef EVENT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ANNOUNCE = 3'd1,
        S_EFFECT   = 3'd2,
        S_DONE     = 3'd3,
        S_WIN      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       act_code_q, act_code_d;
    logic             act_player_q, act_player_d;
    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       pend_code_q, pend_code_d;
    logic             pend_player_q, pend_player_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [3:0]       id_q, id_d;
    logic             player_q, player_d;
    logic             effect_start_q, effect_start_d;
    logic             end_tick_q, end_tick_d;
    logic             game_over_q, game_over_d;
    logic             overflow_q, overflow_d;
    logic             bad_code_q, bad_code_d;
    logic [7:0]       count_q, count_d;
`ifdef EVENT_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    logic       code_ok;
    logic [3:0] req_code_n;
    logic       req_ok;
    logic       launch;
    logic [3:0] l_code;
    logic       l_player;
    logic       take_req;

    always_comb begin
        code_ok = 1'b0;
        case (event_code)
            4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10: code_ok = 1'b1;
            default:                                   code_ok = 1'b0;
        endcase
        req_code_n = code_ok ? event_code : 4'd0;
        // Once the game is won every request is ignored, including its error flags.
        req_ok     = event_req && (state_q != S_WIN);

        state_d       = state_q;
        cnt_d         = cnt_q;
        act_code_d    = act_code_q;
        act_player_d  = act_player_q;
        pend_valid_d  = pend_valid_q;
        pend_code_d   = pend_code_q;
        pend_player_d = pend_player_q;
        overflow_d    = overflow_q;
        bad_code_d    = bad_code_q;
        launch        = 1'b0;
        l_code        = 4'd0;
        l_player      = 1'b0;
        take_req      = 1'b0;
`ifdef EVENT_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q) begin
                    launch       = 1'b1;
                    l_code       = pend_code_q;
                    l_player     = pend_player_q;
                    pend_valid_d = 1'b0;
                end else if (req_ok) begin
                    launch   = 1'b1;
                    l_code   = req_code_n;
                    l_player = req_player;
                    take_req = 1'b1;
                end
            end
            S_ANNOUNCE: begin
                if (cnt_q == ANN_LAST) begin
                    state_d = S_EFFECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EFFECT: begin
                if (anim_done) begin
                    state_d = S_DONE;
`ifdef EVENT_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (pend_valid_q) begin
                    launch       = 1'b1;
                    l_code       = pend_code_q;
                    l_player     = pend_player_q;
                    pend_valid_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WIN: begin
                state_d = S_WIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            act_code_d   = l_code;
            act_player_d = l_player;
            cnt_d        = '0;
            if (l_code == 4'd0)       state_d = S_DONE;
            else if (l_code == 4'd10) state_d = S_WIN;
            else                      state_d = S_ANNOUNCE;
        end

        // Slot occupancy is judged on the registered value, so a slot being served this cycle still rejects.
        if (req_ok && !take_req) begin
            if (pend_valid_q) begin
                overflow_d = 1'b1;
            end else begin
                pend_valid_d  = 1'b1;
                pend_code_d   = req_code_n;
                pend_player_d = req_player;
            end
        end
        if (req_ok && !code_ok) bad_code_d = 1'b1;

        busy_d         = (state_d != S_IDLE);
        valid_d        = (state_d == S_ANNOUNCE) || (state_d == S_EFFECT);
        id_d           = (state_d == S_IDLE) ? 4'd0 : act_code_d;
        player_d       = (state_d == S_IDLE) ? 1'b0 : act_player_d;
        effect_start_d = (state_d == S_EFFECT) && (state_q != S_EFFECT);
        end_tick_d     = (state_d == S_DONE);
        game_over_d    = game_over_q || (state_d == S_WIN);
        count_d        = count_q;
        if ((state_d == S_DONE) && (act_code_d != 4'd0)) count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            act_code_q     <= 4'd0;
            act_player_q   <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_code_q    <= 4'd0;
            pend_player_q  <= 1'b0;
            busy_q         <= 1'b0;
            valid_q        <= 1'b0;
            id_q           <= 4'd0;
            player_q       <= 1'b0;
            effect_start_q <= 1'b0;
            end_tick_q     <= 1'b0;
            game_over_q    <= 1'b0;
            overflow_q     <= 1'b0;
            bad_code_q     <= 1'b0;
            count_q        <= 8'd0;
`ifdef EVENT_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            act_code_q     <= act_code_d;
            act_player_q   <= act_player_d;
            pend_valid_q   <= pend_valid_d;
            pend_code_q    <= pend_code_d;
            pend_player_q  <= pend_player_d;
            busy_q         <= busy_d;
            valid_q        <= valid_d;
            id_q           <= id_d;
            player_q       <= player_d;
            effect_start_q <= effect_start_d;
            end_tick_q     <= end_tick_d;
            game_over_q    <= game_over_d;
            overflow_q     <= overflow_d;
            bad_code_q     <= bad_code_d;
            count_q        <= count_d;
`ifdef EVENT_TIMEOUT_EN
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign ui_event_valid = valid_q;
    assign ui_event_id    = id_q;
    assign ui_player      = player_q;
    assign effect_start   = effect_start_q;
    assign event_end_tick = end_tick_q;
    assign game_over      = game_over_q;
    assign overflow       = overflow_q;
    assign bad_code       = bad_code_q;
    assign event_count    = count_q;
`ifdef EVENT_TIMEOUT_EN
    assign timeout_flag   = timeout_q;
`endif

endmodule

// File: tb/tb_event_sequencer.sv
// tb/tb_event_sequencer.sv - directed self-checking bench for event_sequencer (ANNOUNCE_CYC=4, TIMEOUT_CYC=20).
module tb_event_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       event_req;
    logic [3:0] event_code;
    logic       req_player;
    logic       anim_done;
    logic       busy;
    logic       ui_event_valid;
    logic [3:0] ui_event_id;
    logic       ui_player;
    logic       effect_start;
    logic       event_end_tick;
    logic       game_over;
    logic       overflow;
    logic       bad_code;
    logic [7:0] event_count;
`ifdef EVENT_TIMEOUT_EN
    logic       timeout_flag;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    event_sequencer #(.ANNOUNCE_CYC(4), .TIMEOUT_CYC(20)) dut (
        .clk            (clk),
        .reset          (reset),
        .event_req      (event_req),
        .event_code     (event_code),
        .req_player     (req_player),
        .anim_done      (anim_done),
        .busy           (busy),
        .ui_event_valid (ui_event_valid),
        .ui_event_id    (ui_event_id),
        .ui_player      (ui_player),
        .effect_start   (effect_start),
        .event_end_tick (event_end_tick),
        .game_over      (game_over),
        .overflow       (overflow),
        .bad_code       (bad_code),
`ifdef EVENT_TIMEOUT_EN
        .timeout_flag   (timeout_flag),
`endif
        .event_count    (event_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] c, input logic p);
        event_req  = 1'b1;
        event_code = c;
        req_player = p;
        tick();
        event_req  = 1'b0;
        event_code = 4'd0;
        req_player = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        event_req  = 1'b0;
        event_code = 4'd0;
        req_player = 1'b0;
        anim_done  = 1'b0;
        do_reset();

        chk("rst_busy", busy, 0);
        chk("rst_valid", ui_event_valid, 0);
        chk("rst_id", ui_event_id, 0);
        chk("rst_player", ui_player, 0);
        chk("rst_estart", effect_start, 0);
        chk("rst_end", event_end_tick, 0);
        chk("rst_gover", game_over, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bad", bad_code, 0);
        chk("rst_count", event_count, 0);

        // code 0: completion tick in the very next cycle, no count
        req(4'd0, 1'b0);
        chk("c0_end", event_end_tick, 1);
        chk("c0_busy", busy, 1);
        chk("c0_valid", ui_event_valid, 0);
        chk("c0_count", event_count, 0);
        tick();
        chk("c0_end_off", event_end_tick, 0);
        chk("c0_busy_off", busy, 0);

        // code 4, player 1; stray anim_done during ANNOUNCE must be ignored
        req(4'd4, 1'b1);
        chk("c4_valid_n1", ui_event_valid, 1);
        chk("c4_id_n1", ui_event_id, 4);
        chk("c4_player", ui_player, 1);
        chk("c4_estart_n1", effect_start, 0);
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        chk("c4_valid_n2", ui_event_valid, 1);
        chk("c4_estart_n2", effect_start, 0);
        tick();
        tick();
        chk("c4_estart_n4", effect_start, 0);
        tick();
        chk("c4_estart_n5", effect_start, 1);
        chk("c4_id_n5", ui_event_id, 4);
        tick();
        chk("c4_estart_n6", effect_start, 0);
        tick();
        tick();
        chk("c4_valid_n8", ui_event_valid, 1);
        chk("c4_end_n8", event_end_tick, 0);
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        chk("c4_end_n9", event_end_tick, 1);
        chk("c4_count", event_count, 1);
        chk("c4_id_n9", ui_event_id, 4);
        chk("c4_valid_n9", ui_event_valid, 0);
        tick();
        chk("c4_busy_n10", busy, 0);
        chk("c4_id_n10", ui_event_id, 0);
        chk("c4_end_n10", event_end_tick, 0);

        // back-to-back 2/6/8: 6 pends, 8 overflows
        do_reset();
        event_req = 1'b1; event_code = 4'd2; req_player = 1'b0;
        tick();
        event_code = 4'd6; req_player = 1'b1;
        tick();
        event_code = 4'd8; req_player = 1'b0;
        tick();
        event_req = 1'b0; event_code = 4'd0;
        chk("b2b_ovf", overflow, 1);
        chk("b2b_id2", ui_event_id, 2);
        chk("b2b_pl2", ui_player, 0);
        tick();
        tick();
        chk("b2b_estart2", effect_start, 1);
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        chk("b2b_end2", event_end_tick, 1);
        chk("b2b_count1", event_count, 1);
        tick();
        chk("b2b_valid6", ui_event_valid, 1);
        chk("b2b_id6", ui_event_id, 6);
        chk("b2b_pl6", ui_player, 1);
        chk("b2b_end_off", event_end_tick, 0);
        tick(); tick(); tick(); tick();
        chk("b2b_estart6", effect_start, 1);
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        chk("b2b_end6", event_end_tick, 1);
        chk("b2b_count2", event_count, 2);
        tick();
        chk("b2b_idle", busy, 0);
        chk("b2b_ovf_sticky", overflow, 1);

        // unknown code 7 behaves like code 0
        req(4'd7, 1'b0);
        chk("c7_bad", bad_code, 1);
        chk("c7_end", event_end_tick, 1);
        chk("c7_id", ui_event_id, 0);
        chk("c7_count", event_count, 2);
        tick();
        chk("c7_idle", busy, 0);

        // reset during EFFECT aborts without an end tick
        req(4'd3, 1'b0);
        tick(); tick(); tick(); tick();
        chk("rs_estart", effect_start, 1);
`ifndef EVENT_TIMEOUT_EN
        repeat (25) tick();
        chk("rs_wait_valid", ui_event_valid, 1);
        chk("rs_wait_end", event_end_tick, 0);
`endif
        reset = 1'b1;
        tick();
        chk("rs_busy", busy, 0);
        chk("rs_valid", ui_event_valid, 0);
        chk("rs_end", event_end_tick, 0);
        chk("rs_id", ui_event_id, 0);
        chk("rs_count", event_count, 0);
        chk("rs_bad", bad_code, 0);
        chk("rs_ovf", overflow, 0);
        reset = 1'b0;
        tick();
        chk("rs_end_after", event_end_tick, 0);
        chk("rs_busy_after", busy, 0);

        // code 10 locks the sequencer in WIN
        req(4'd10, 1'b1);
        chk("win_gover", game_over, 1);
        chk("win_busy", busy, 1);
        chk("win_id", ui_event_id, 10);
        chk("win_valid", ui_event_valid, 0);
        chk("win_end", event_end_tick, 0);
        req(4'd2, 1'b0);
        req(4'd5, 1'b0);
        tick();
        tick();
        chk("win_gover_hold", game_over, 1);
        chk("win_busy_hold", busy, 1);
        chk("win_id_hold", ui_event_id, 10);
        chk("win_valid_hold", ui_event_valid, 0);
        chk("win_bad", bad_code, 0);
        chk("win_ovf", overflow, 0);
        chk("win_count", event_count, 0);

`ifdef EVENT_TIMEOUT_EN
        do_reset();
        req(4'd4, 1'b0);
        tick(); tick(); tick(); tick();
        chk("to_estart", effect_start, 1);
        repeat (19) tick();
        chk("to_end_early", event_end_tick, 0);
        chk("to_flag_early", timeout_flag, 0);
        tick();
        chk("to_end", event_end_tick, 1);
        chk("to_flag", timeout_flag, 1);
        chk("to_count", event_count, 1);
        tick();
        chk("to_idle", busy, 0);
        chk("to_flag_sticky", timeout_flag, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/event_sequencer.md
# event_sequencer

Sequences board-square events for the dice race game. The game FSM raises a request carrying an event code. This block then runs a timed announce phase, triggers the UI effect animation, waits for it to finish, and returns a one-cycle `event_end_tick`. It sits between the game FSM and the UI/overlay renderer. It holds one pending request so that back-to-back requests are not lost.

## Interface
- `ANNOUNCE_CYC`, default 50_000_000: cycles the event banner is shown before the effect starts (≥2).
- `TIMEOUT_CYC`, default 300_000_000: effect watchdog limit in cycles. Used only when `EVENT_TIMEOUT_EN` is defined.
- `clk` in 1: system clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `event_req` in 1: one-cycle request strobe.
- `event_code` in 4: event code, sampled together with `event_req`.
- `req_player` in 1: player who triggered the event (0 = P1, 1 = P2), sampled with `event_req`.
- `anim_done` in 1: UI strobe marking the end of the effect animation.
- `busy` out 1: high in every state except IDLE.
- `ui_event_valid` out 1: high during ANNOUNCE and EFFECT.
- `ui_event_id` out 4: code of the active event; 0 when idle.
- `ui_player` out 1: player of the active event.
- `effect_start` out 1: one-cycle pulse on entry to EFFECT.
- `event_end_tick` out 1: one-cycle completion pulse.
- `game_over` out 1: sticky, set by code 10.
- `overflow` out 1: sticky, a request was dropped.
- `bad_code` out 1: sticky, an unknown code was received.
- `event_count` out 8: number of completed events (codes 2/3/4/6/8), wraps at 255→0.

## Operation
- Valid codes: 0 (none), 2, 3, 4, 6, 8 (effects), 10 (win).
- Any other code sets `bad_code` and is then treated as 0.
- FSM states: IDLE, ANNOUNCE, EFFECT, DONE, WIN.
- IDLE:
  - On an accepted request with code 0, go to DONE with no effect.
  - With code 10, go to WIN.
  - With an effect code, go to ANNOUNCE and clear the phase counter.
- ANNOUNCE: count up to `ANNOUNCE_CYC`−1, then go to EFFECT.
- EFFECT:
  - `effect_start` pulses on the first cycle only.
  - Stay until `anim_done`, then go to DONE.
  - `anim_done` in the same cycle as entry to EFFECT is honoured.
- DONE:
  - `event_end_tick`=1 for exactly this one cycle.
  - `event_count` increments if the code was nonzero.
  - Next state: ANNOUNCE/DONE/WIN from the pending slot if it is full (slot is cleared), else IDLE.
- WIN:
  - `game_over`=1 and `ui_event_id`=10.
  - Held until reset; all further requests are ignored; `overflow` is not set.
- Pending slot (one entry of code + player):
  - A request arriving when state ≠ IDLE (or during the IDLE→X transition cycle) fills the slot.
  - A request arriving while the slot is already full is dropped and sets `overflow`.
- `anim_done` outside EFFECT is ignored.
- Active code and player are latched at acceptance and are stable until DONE completes.

## Timing
- Reset values: all outputs 0, state IDLE, pending slot empty, counters 0.
- Reset mid-operation aborts immediately; no `event_end_tick` is emitted.
- Request accepted at edge N with an effect code:
  - `ui_event_valid`=1 from cycle N+1.
  - EFFECT entered at N+1+`ANNOUNCE_CYC`; `effect_start` pulses in that cycle.
- `anim_done` at cycle M in EFFECT → `event_end_tick` at M+1 → IDLE at M+2.
- Code 0: `event_end_tick` at N+1.
- Pending slot is served directly from DONE, with no IDLE cycle in between.
- `busy` and `ui_event_valid` are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- `EVENT_TIMEOUT_EN` defined:
  - EFFECT has a watchdog counter.
  - After `TIMEOUT_CYC` cycles without `anim_done`, go to DONE as normal and set sticky output `timeout_flag` (1 bit, reset 0).
- `EVENT_TIMEOUT_EN` undefined:
  - EFFECT waits indefinitely.
  - `timeout_flag` port is absent.

## Test plan
- Test parameters: `ANNOUNCE_CYC`=4, `TIMEOUT_CYC`=20.
- Code 4, player 1 at cycle 10:
  - `ui_event_valid` over cycles 11–18, `effect_start` at 15.
  - `anim_done` at 18 → `event_end_tick` at 19, `event_count`=1, `ui_event_id`=4 throughout.
- Code 0 at cycle 5 → `event_end_tick` at 6, `busy` high only at 6, `event_count` stays 0.
- Codes 2 (P1), 6 (P2), 8 (P1) in consecutive cycles:
  - 2 runs first, 6 is pending and starts in the cycle after the first end tick.
  - 8 is dropped, `overflow`=1, `event_count`=2.
- Code 10 → `game_over`=1 and `busy`=1 permanently; a later code 2 changes nothing.
- Code 7 → `bad_code`=1, `event_end_tick` next cycle.
- `reset` during EFFECT → all outputs 0 the next cycle, no end tick.
- With `EVENT_TIMEOUT_EN` and no `anim_done`: `timeout_flag`=1 and `event_end_tick` at EFFECT entry + 20.
